// File: rtl/axi_mem_pkg.sv
// Shared response codes, FSM state types and the burst-response helper
// for the AXI4 burst memory slave.
package axi_mem_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rstate_e;

    // A burst is well formed only when WLAST lands on the beat AWLEN announced.
    function automatic logic [1:0] last_beat_resp(input logic [7:0] beat, input logic [7:0] len);
        return (beat == len) ? RESP_OKAY : RESP_SLVERR;
    endfunction

endpackage

// File: rtl/axi_mem_dpram.sv
// Simple dual-port RAM: byte-enable write port, synchronous read-first read
// port whose output register holds while the read enable is low.
module axi_mem_dpram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [ADDR_W-1:0]     waddr_i,
    input  logic [DATA_W/8-1:0]   wbe_i,
    input  logic [DATA_W-1:0]     wdata_i,
    input  logic                  re_i,
    input  logic [ADDR_W-1:0]     raddr_i,
    output logic [DATA_W-1:0]     rdata_o
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Both ports update with non-blocking assignments, so a same-word
    // read and write in one cycle returns the old contents.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < DATA_W/8; b++) begin
                if (wbe_i[b]) begin
                    mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/axi_burst_mem_slave.sv
// AXI4 INCR burst slave over a 1 KiB RAM; independent write and read FSMs,
// one read beat per cycle, bursts wrap at the top of the memory.
module axi_burst_mem_slave
    import axi_mem_pkg::*;
#(
    parameter int C_S_AXI_ID_WIDTH   = 1,
    parameter int C_S_AXI_ADDR_WIDTH = 10,
    parameter int C_S_AXI_DATA_WIDTH = 32
) (
    input  logic                          ACLK,
    input  logic                          ARESET,
    input  logic [C_S_AXI_ID_WIDTH-1:0]   S_AXI_AWID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
    input  logic [7:0]                    S_AXI_AWLEN,
    input  logic                          S_AXI_AWVALID,
    output logic                          S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_WDATA,
    input  logic [3:0]                    S_AXI_WSTRB,
    input  logic                          S_AXI_WLAST,
    input  logic                          S_AXI_WVALID,
    output logic                          S_AXI_WREADY,
    output logic [C_S_AXI_ID_WIDTH-1:0]   S_AXI_BID,
    output logic [1:0]                    S_AXI_BRESP,
    output logic                          S_AXI_BVALID,
    input  logic                          S_AXI_BREADY,
    input  logic [C_S_AXI_ID_WIDTH-1:0]   S_AXI_ARID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
    input  logic [7:0]                    S_AXI_ARLEN,
    input  logic                          S_AXI_ARVALID,
    output logic                          S_AXI_ARREADY,
    output logic [C_S_AXI_ID_WIDTH-1:0]   S_AXI_RID,
    output logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_RDATA,
    output logic [1:0]                    S_AXI_RRESP,
    output logic                          S_AXI_RLAST,
    output logic                          S_AXI_RVALID,
    input  logic                          S_AXI_RREADY
);

    localparam int WORD_W = C_S_AXI_ADDR_WIDTH - 2;

    wstate_e                       w_state_q;
    logic                          awready_q, wready_q, bvalid_q;
    logic [1:0]                    bresp_q;
    logic [C_S_AXI_ID_WIDTH-1:0]   bid_q;
    logic [WORD_W-1:0]             waddr_q;
    logic [7:0]                    awlen_q, wbeat_q;

    rstate_e                       r_state_q;
    logic                          arready_q, rvalid_q, rlast_q;
    logic [C_S_AXI_ID_WIDTH-1:0]   rid_q;
    logic [WORD_W-1:0]             raddr_q;
    logic [7:0]                    rlen_q, rbeat_q;

    logic                          ram_we, ram_re;
    logic [C_S_AXI_DATA_WIDTH-1:0] ram_rdata;
    logic                          unused_addr_lsbs;

    assign unused_addr_lsbs = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    assign ram_we = (w_state_q == W_DATA) && S_AXI_WVALID;
    assign ram_re = (r_state_q == R_FETCH) ||
                    ((r_state_q == R_DATA) && S_AXI_RREADY && !rlast_q);

    axi_mem_dpram #(
        .ADDR_W (WORD_W),
        .DATA_W (C_S_AXI_DATA_WIDTH)
    ) u_ram (
        .clk_i   (ACLK),
        .we_i    (ram_we),
        .waddr_i (waddr_q),
        .wbe_i   (S_AXI_WSTRB),
        .wdata_i (S_AXI_WDATA),
        .re_i    (ram_re),
        .raddr_i (raddr_q),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            bid_q     <= '0;
        end else begin
            case (w_state_q)
                W_IDLE: begin
                    awready_q <= 1'b1;
                    if (awready_q && S_AXI_AWVALID) begin
                        awready_q <= 1'b0;
                        wready_q  <= 1'b1;
                        bid_q     <= S_AXI_AWID;
                        waddr_q   <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
                        awlen_q   <= S_AXI_AWLEN;
                        wbeat_q   <= 8'd0;
                        w_state_q <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (S_AXI_WVALID) begin
                        waddr_q <= waddr_q + 1'b1;
                        wbeat_q <= wbeat_q + 8'd1;
                        if (S_AXI_WLAST) begin
                            wready_q  <= 1'b0;
                            bvalid_q  <= 1'b1;
                            bresp_q   <= last_beat_resp(wbeat_q, awlen_q);
                            w_state_q <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (S_AXI_BREADY) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        w_state_q <= W_IDLE;
                    end
                end
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    // RAM output lands one cycle after each read enable, so the fetch state
    // primes beat 0 and every accepted non-last beat prefetches the next.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rid_q     <= '0;
        end else begin
            case (r_state_q)
                R_IDLE: begin
                    arready_q <= 1'b1;
                    if (arready_q && S_AXI_ARVALID) begin
                        arready_q <= 1'b0;
                        rid_q     <= S_AXI_ARID;
                        raddr_q   <= S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
                        rlen_q    <= S_AXI_ARLEN;
                        rbeat_q   <= 8'd0;
                        r_state_q <= R_FETCH;
                    end
                end
                R_FETCH: begin
                    raddr_q   <= raddr_q + 1'b1;
                    rvalid_q  <= 1'b1;
                    rlast_q   <= (rlen_q == 8'd0);
                    r_state_q <= R_DATA;
                end
                R_DATA: begin
                    if (S_AXI_RREADY) begin
                        if (rlast_q) begin
                            rvalid_q  <= 1'b0;
                            rlast_q   <= 1'b0;
                            arready_q <= 1'b1;
                            r_state_q <= R_IDLE;
                        end else begin
                            raddr_q <= raddr_q + 1'b1;
                            rbeat_q <= rbeat_q + 8'd1;
                            rlast_q <= ((rbeat_q + 8'd1) == rlen_q);
                        end
                    end
                end
                default: r_state_q <= R_IDLE;
            endcase
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BID     = bid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RID     = rid_q;
    assign S_AXI_RDATA   = rvalid_q ? ram_rdata : '0;
    assign S_AXI_RRESP   = RESP_OKAY;
    assign S_AXI_RLAST   = rlast_q;
    assign S_AXI_RVALID  = rvalid_q;

endmodule

// File: tb/tb_axi_burst_mem_slave.sv
// Directed bench for axi_burst_mem_slave: burst round trips, strobes, wrap,
// backpressure, early WLAST and reset mid-burst, plus a single-beat read table.
module tb_axi_burst_mem_slave;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [0:0]  S_AXI_AWID;
    logic [9:0]  S_AXI_AWADDR;
    logic [7:0]  S_AXI_AWLEN;
    logic        S_AXI_AWVALID;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA;
    logic [3:0]  S_AXI_WSTRB;
    logic        S_AXI_WLAST;
    logic        S_AXI_WVALID;
    logic        S_AXI_WREADY;
    logic [0:0]  S_AXI_BID;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY;
    logic [0:0]  S_AXI_ARID;
    logic [9:0]  S_AXI_ARADDR;
    logic [7:0]  S_AXI_ARLEN;
    logic        S_AXI_ARVALID;
    logic        S_AXI_ARREADY;
    logic [0:0]  S_AXI_RID;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RLAST;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY;

    axi_burst_mem_slave #(
        .C_S_AXI_ID_WIDTH   (1),
        .C_S_AXI_ADDR_WIDTH (10),
        .C_S_AXI_DATA_WIDTH (32)
    ) dut (
        .ACLK          (ACLK),
        .ARESET        (ARESET),
        .S_AXI_AWID    (S_AXI_AWID),
        .S_AXI_AWADDR  (S_AXI_AWADDR),
        .S_AXI_AWLEN   (S_AXI_AWLEN),
        .S_AXI_AWVALID (S_AXI_AWVALID),
        .S_AXI_AWREADY (S_AXI_AWREADY),
        .S_AXI_WDATA   (S_AXI_WDATA),
        .S_AXI_WSTRB   (S_AXI_WSTRB),
        .S_AXI_WLAST   (S_AXI_WLAST),
        .S_AXI_WVALID  (S_AXI_WVALID),
        .S_AXI_WREADY  (S_AXI_WREADY),
        .S_AXI_BID     (S_AXI_BID),
        .S_AXI_BRESP   (S_AXI_BRESP),
        .S_AXI_BVALID  (S_AXI_BVALID),
        .S_AXI_BREADY  (S_AXI_BREADY),
        .S_AXI_ARID    (S_AXI_ARID),
        .S_AXI_ARADDR  (S_AXI_ARADDR),
        .S_AXI_ARLEN   (S_AXI_ARLEN),
        .S_AXI_ARVALID (S_AXI_ARVALID),
        .S_AXI_ARREADY (S_AXI_ARREADY),
        .S_AXI_RID     (S_AXI_RID),
        .S_AXI_RDATA   (S_AXI_RDATA),
        .S_AXI_RRESP   (S_AXI_RRESP),
        .S_AXI_RLAST   (S_AXI_RLAST),
        .S_AXI_RVALID  (S_AXI_RVALID),
        .S_AXI_RREADY  (S_AXI_RREADY)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        logic [9:0]  addr;
        logic [31:0] exp;
    } rvec_t;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] wd_buf [16];
    logic [3:0]  ws_buf [16];
    logic [31:0] rd_buf [16];
    logic [1:0]  b_resp;
    logic [0:0]  b_id;
    rvec_t       vecs [12];

    function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endfunction

    function automatic logic [63:0] all_outputs();
        return {20'd0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BID, S_AXI_BRESP, S_AXI_BVALID,
                S_AXI_ARREADY, S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID};
    endfunction

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    // Beats 0..nbeats-1 come from wd_buf/ws_buf; WLAST goes on beat nbeats-1.
    task automatic write_burst(input logic [9:0] addr, input logic [7:0] len, input logic [0:0] id,
                               input int nbeats, output logic [1:0] resp, output logic [0:0] bid);
        int t;
        S_AXI_AWADDR  = addr;
        S_AXI_AWLEN   = len;
        S_AXI_AWID    = id;
        S_AXI_AWVALID = 1'b1;
        for (t = 0; t < 50 && !S_AXI_AWREADY; t++) tick();
        check("aw_ready_wait", S_AXI_AWREADY, 1'b1);
        tick();
        S_AXI_AWVALID = 1'b0;
        check("wready_after_aw", S_AXI_WREADY, 1'b1);
        for (int i = 0; i < nbeats; i++) begin
            S_AXI_WDATA  = wd_buf[i];
            S_AXI_WSTRB  = ws_buf[i];
            S_AXI_WLAST  = (i == nbeats - 1);
            S_AXI_WVALID = 1'b1;
            tick();
        end
        S_AXI_WVALID = 1'b0;
        S_AXI_WLAST  = 1'b0;
        check("bvalid_after_wlast", S_AXI_BVALID, 1'b1);
        check("wready_after_wlast", S_AXI_WREADY, 1'b0);
        resp = S_AXI_BRESP;
        bid  = S_AXI_BID;
        S_AXI_BREADY = 1'b1;
        tick();
        S_AXI_BREADY = 1'b0;
        check("awready_after_b", S_AXI_AWREADY, 1'b1);
    endtask

    // With toggle set, RREADY follows 1,0,1,0 over the cycles RVALID is high.
    task automatic read_burst(input logic [9:0] addr, input logic [7:0] len, input logic [0:0] id,
                              input bit toggle);
        int          t, cyc, nb, k;
        bit          stalled;
        logic [31:0] held_data;
        logic        held_last;
        logic        rr;
        S_AXI_ARADDR  = addr;
        S_AXI_ARLEN   = len;
        S_AXI_ARID    = id;
        S_AXI_ARVALID = 1'b1;
        for (t = 0; t < 50 && !S_AXI_ARREADY; t++) tick();
        check("ar_ready_wait", S_AXI_ARREADY, 1'b1);
        tick();
        S_AXI_ARVALID = 1'b0;
        cyc = 0; nb = 0; k = 0; stalled = 0;
        held_data = '0; held_last = 1'b0;
        while (nb < int'(len) + 1 && cyc < 1000) begin
            if (cyc == 0) check("rvalid_fetch_cycle", S_AXI_RVALID, 1'b0);
            if (cyc == 1) begin
                check("rvalid_at_ar_plus2", S_AXI_RVALID, 1'b1);
                check("rid_echo", S_AXI_RID, id);
            end
            rr = 1'b0;
            if (S_AXI_RVALID) begin
                if (stalled) begin
                    check("rdata_stall_stable", S_AXI_RDATA, held_data);
                    check("rlast_stall_stable", S_AXI_RLAST, held_last);
                end
                rr = toggle ? (k % 2 == 0) : 1'b1;
                k++;
                if (rr) begin
                    rd_buf[nb] = S_AXI_RDATA;
                    check($sformatf("rlast_beat%0d", nb), S_AXI_RLAST, (nb == int'(len)));
                    nb++;
                    stalled = 0;
                end else begin
                    held_data = S_AXI_RDATA;
                    held_last = S_AXI_RLAST;
                    stalled   = 1;
                end
            end
            S_AXI_RREADY = rr;
            tick();
            cyc++;
        end
        S_AXI_RREADY = 1'b0;
        check("read_beat_count", nb, int'(len) + 1);
        if (!toggle) check("read_cycles", cyc, int'(len) + 2);
        check("arready_after_rlast", S_AXI_ARREADY, 1'b1);
        check("rvalid_after_rlast", S_AXI_RVALID, 1'b0);
    endtask

    initial begin
        ARESET = 1'b1;
        S_AXI_AWID = '0; S_AXI_AWADDR = '0; S_AXI_AWLEN = '0; S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WLAST = 1'b0; S_AXI_WVALID = 1'b0;
        S_AXI_BREADY = 1'b0;
        S_AXI_ARID = '0; S_AXI_ARADDR = '0; S_AXI_ARLEN = '0; S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY = 1'b0;

        vecs[0]  = '{10'h010, 32'h11111111};
        vecs[1]  = '{10'h013, 32'h11111111};
        vecs[2]  = '{10'h01C, 32'h44444444};
        vecs[3]  = '{10'h020, 32'h00BB00DD};
        vecs[4]  = '{10'h3F8, 32'h00000001};
        vecs[5]  = '{10'h3FC, 32'h00000002};
        vecs[6]  = '{10'h000, 32'h00000003};
        vecs[7]  = '{10'h004, 32'h00000004};
        vecs[8]  = '{10'h100, 32'h000000B0};
        vecs[9]  = '{10'h108, 32'h000000A2};
        vecs[10] = '{10'h10C, 32'h000000A3};
        vecs[11] = '{10'h21C, 32'h00001007};

        repeat (3) tick();
        check("reset_outputs_zero", all_outputs(), 64'd0);
        ARESET = 1'b0;
        tick();
        check("awready_after_reset", S_AXI_AWREADY, 1'b1);
        check("arready_after_reset", S_AXI_ARREADY, 1'b1);

        // Round trip
        for (int i = 0; i < 4; i++) begin
            wd_buf[i] = 32'h11111111 * (i + 1);
            ws_buf[i] = 4'hF;
        end
        write_burst(10'h010, 8'd3, 1'b1, 4, b_resp, b_id);
        check("rt_bresp", b_resp, 2'b00);
        check("rt_bid", b_id, 1'b1);
        read_burst(10'h010, 8'd3, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++)
            check($sformatf("rt_rdata%0d", i), rd_buf[i], 32'h11111111 * (i + 1));

        // Byte strobes over a zeroed word
        wd_buf[0] = 32'h0; ws_buf[0] = 4'hF;
        write_burst(10'h020, 8'd0, 1'b0, 1, b_resp, b_id);
        wd_buf[0] = 32'hAABBCCDD; ws_buf[0] = 4'h5;
        write_burst(10'h020, 8'd0, 1'b0, 1, b_resp, b_id);
        check("strb_bresp", b_resp, 2'b00);
        read_burst(10'h020, 8'd0, 1'b0, 1'b0);
        check("strb_rdata", rd_buf[0], 32'h00BB00DD);

        // Wrap at the 1 KiB boundary, on both write and read
        for (int i = 0; i < 4; i++) begin
            wd_buf[i] = i + 1;
            ws_buf[i] = 4'hF;
        end
        write_burst(10'h3F8, 8'd3, 1'b0, 4, b_resp, b_id);
        check("wrap_bresp", b_resp, 2'b00);
        read_burst(10'h3F8, 8'd3, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++)
            check($sformatf("wrap_rdata%0d", i), rd_buf[i], i + 1);

        // Early WLAST: beats 0-1 overwrite, beats 2-3 keep prior contents
        for (int i = 0; i < 4; i++) begin
            wd_buf[i] = 32'hA0 + i;
            ws_buf[i] = 4'hF;
        end
        write_burst(10'h100, 8'd3, 1'b0, 4, b_resp, b_id);
        wd_buf[0] = 32'hB0; wd_buf[1] = 32'hB1;
        write_burst(10'h100, 8'd3, 1'b1, 2, b_resp, b_id);
        check("early_wlast_bresp", b_resp, 2'b10);
        check("early_wlast_bid", b_id, 1'b1);
        read_burst(10'h100, 8'd3, 1'b0, 1'b0);
        check("early_rdata0", rd_buf[0], 32'hB0);
        check("early_rdata1", rd_buf[1], 32'hB1);
        check("early_rdata2", rd_buf[2], 32'hA2);
        check("early_rdata3", rd_buf[3], 32'hA3);

        // Backpressure on an 8-beat read
        for (int i = 0; i < 8; i++) begin
            wd_buf[i] = 32'h1000 + i;
            ws_buf[i] = 4'hF;
        end
        write_burst(10'h200, 8'd7, 1'b0, 8, b_resp, b_id);
        read_burst(10'h200, 8'd7, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++)
            check($sformatf("bp_rdata%0d", i), rd_buf[i], 32'h1000 + i);

        // Reset in the middle of a read burst
        S_AXI_ARADDR = 10'h200; S_AXI_ARLEN = 8'd7; S_AXI_ARID = 1'b1; S_AXI_ARVALID = 1'b1;
        for (int t = 0; t < 50 && !S_AXI_ARREADY; t++) tick();
        tick();
        S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY  = 1'b1;
        repeat (3) tick();
        check("midburst_rvalid", S_AXI_RVALID, 1'b1);
        ARESET = 1'b1;
        S_AXI_RREADY = 1'b0;
        repeat (5) tick();
        check("midburst_reset_outputs_zero", all_outputs(), 64'd0);
        ARESET = 1'b0;
        tick();
        check("awready_after_midburst_reset", S_AXI_AWREADY, 1'b1);
        check("arready_after_midburst_reset", S_AXI_ARREADY, 1'b1);
        check("rvalid_after_midburst_reset", S_AXI_RVALID, 1'b0);

        // Memory survives reset; single-beat reads from the table
        for (int i = 0; i < 12; i++) begin
            read_burst(vecs[i].addr, 8'd0, 1'b0, 1'b0);
            check($sformatf("tbl%0d_rdata_%0h", i, vecs[i].addr), rd_buf[0], vecs[i].exp);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/axi_burst_mem_slave.md
# axi_burst_mem_slave

AXI4 burst slave backed by a 1 KiB on-chip memory. It is the responder end of the AXI_prefetch1k master port: it accepts INCR write and read bursts, stores write data with byte strobes and returns read data at one beat per cycle. It closes the loop in block-design simulation and serves as a PL scratch memory on the PYNQ-Z1.

## Interface
Parameters:
- C_S_AXI_ID_WIDTH, 1, width of the AWID/BID/ARID/RID fields.
- C_S_AXI_ADDR_WIDTH, 10, byte address width. Memory depth is 2^(ADDR_WIDTH-2) words.
- C_S_AXI_DATA_WIDTH, 32, fixed. Other values are not supported.

Ports (one clock, ACLK; reset ARESET is synchronous and active-high):
- ACLK in 1: clock.
- ARESET in 1: synchronous active-high reset.
- S_AXI_AWID in ID: write ID.
- S_AXI_AWADDR in ADDR: write start byte address.
- S_AXI_AWLEN in 8: beats minus 1.
- S_AXI_AWVALID in 1 / S_AXI_AWREADY out 1: AW handshake.
- S_AXI_WDATA in 32: write data.
- S_AXI_WSTRB in 4: byte enables.
- S_AXI_WLAST in 1: last write beat.
- S_AXI_WVALID in 1 / S_AXI_WREADY out 1: W handshake.
- S_AXI_BID out ID: echoed AWID.
- S_AXI_BRESP out 2: OKAY (00) or SLVERR (10).
- S_AXI_BVALID out 1 / S_AXI_BREADY in 1: B handshake.
- S_AXI_ARID in ID: read ID.
- S_AXI_ARADDR in ADDR: read start byte address.
- S_AXI_ARLEN in 8: beats minus 1.
- S_AXI_ARVALID in 1 / S_AXI_ARREADY out 1: AR handshake.
- S_AXI_RID out ID: echoed ARID.
- S_AXI_RDATA out 32: read data.
- S_AXI_RRESP out 2: always OKAY.
- S_AXI_RLAST out 1: last read beat.
- S_AXI_RVALID out 1 / S_AXI_RREADY in 1: R handshake.

## Operation
- Burst type and size are not decoded. Every burst is INCR, 4 bytes per beat, and AxADDR[1:0] is ignored.
- Word index for beat n is AxADDR[ADDR_WIDTH-1:2] + n, modulo the depth, so bursts wrap at the 1 KiB boundary.
- Write FSM:
  - W_IDLE (AWREADY=1): an AW handshake latches ID, address and length, then moves to W_DATA.
  - W_DATA (WREADY=1): each W handshake writes the enabled bytes and increments the beat count.
  - A handshake with WLAST=1 moves to W_RESP.
  - W_RESP (BVALID=1): a B handshake returns to W_IDLE.
- BRESP is SLVERR if the WLAST beat index is not equal to AWLEN; otherwise it is OKAY.
- The burst always ends on WLAST. Beats past AWLEN are still written, at wrapped addresses.
- Read FSM:
  - R_IDLE (ARREADY=1): an AR handshake latches the request, then moves to R_FETCH.
  - R_FETCH issues the RAM read for beat 0, then moves to R_DATA.
  - R_DATA (RVALID=1): a non-last handshake issues the read for the next beat in the same cycle. The last handshake returns to R_IDLE.
- RLAST=1 exactly on beat ARLEN.
- The read and write FSMs are fully independent. The RAM is read-first: a same-cycle read and write to the same word returns the old data.
- ARESET at any time:
  - both FSMs return to idle;
  - any in-flight burst is abandoned;
  - memory contents are preserved.

## Timing
- Reset values: every output is 0, including AWREADY and ARREADY. AWREADY and ARREADY go to 1 in the first cycle after ARESET deasserts.
- Write path:
  - AW handshake at cycle N: WREADY=1 at N+1.
  - WLAST handshake at M: BVALID=1 and WREADY=0 at M+1.
  - B handshake at K: AWREADY=1 at K+1.
- Read path:
  - AR handshake at N: RVALID=1 with beat 0 at N+2.
  - Throughput is one beat per cycle while RREADY=1.
  - While RVALID=1 and RREADY=0, RDATA, RLAST and RID hold stable.
  - Last handshake at K: ARREADY=1 at K+1.
- The beat counter is 8 bits; AxLEN=255 gives 256 beats.

## Structure
- Package axi_mem_pkg holds:
  - RESP_OKAY = 2'b00 and RESP_SLVERR = 2'b10;
  - the write-state enum (W_IDLE, W_DATA, W_RESP);
  - the read-state enum (R_IDLE, R_FETCH, R_DATA).
- Sub-module axi_mem_dpram: simple dual-port RAM with 32-bit words, a byte-enable write port, and a synchronous read port with read-enable that holds its output when not enabled.

## Test plan
- Reset: assert ARESET for 5 cycles during an active read burst -> all outputs are 0 and AWREADY/ARREADY are 1 one cycle after release. Earlier writes still read back intact.
- Write/read round trip:
  - write AWADDR=0x010, AWLEN=3, data 0x11111111..0x44444444, WSTRB=0xF -> BRESP=00, BID=AWID;
  - read ARADDR=0x010, ARLEN=3, RREADY=1 -> the same 4 words on consecutive cycles from AR+2, RLAST on the 4th.
- Strobes: write 0xAABBCCDD with WSTRB=0x5 over 0x00000000 at 0x020 -> reads 0x00BB00DD.
- Wrap: write AWADDR=0x3F8, AWLEN=3, data 1..4 -> words 0x3F8, 0x3FC, 0x000, 0x004 read back as 1, 2, 3, 4.
- Backpressure: read ARLEN=7 with RREADY toggling 1,0,1,0 -> 8 beats in order, RDATA/RLAST stable during stalls, RLAST only on beat 7.
- Early WLAST: AWLEN=3 with WLAST on beat 1 -> BRESP=10, beats 0-1 written, beats 2-3 unchanged, FSM returns to idle.
